// File: rtl/enc8b10b_lanes.sv
// Multi-lane clocked 8b/10b encoder with running disparity chained across lanes.
// Optional macro ENC8B10B_RD_FORCE_EN adds rd_force/rd_force_val to load the stored RD.
module enc8b10b_lanes #(
  parameter int LANES   = 1,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     in_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10*LANES-1:0]  out_code,
  output logic [LANES-1:0]     out_kerr,
`ifdef ENC8B10B_RD_FORCE_EN
  input  logic                 rd_force,
  input  logic                 rd_force_val,
`endif
  output logic                 rd_out
);

  typedef struct packed {
    logic [9:0] code;
    logic       kerr;
    logic       rd;
  } lane_res_t;

  // RD- column of the 5B6B table; RD+ codes are the complements of the unbalanced ones and D.7
  function automatic logic [5:0] base6(input logic [4:0] x);
    case (x)
      5'd0:  base6 = 6'b100111;  5'd1:  base6 = 6'b011101;
      5'd2:  base6 = 6'b101101;  5'd3:  base6 = 6'b110001;
      5'd4:  base6 = 6'b110101;  5'd5:  base6 = 6'b101001;
      5'd6:  base6 = 6'b011001;  5'd7:  base6 = 6'b111000;
      5'd8:  base6 = 6'b111001;  5'd9:  base6 = 6'b100101;
      5'd10: base6 = 6'b010101;  5'd11: base6 = 6'b110100;
      5'd12: base6 = 6'b001101;  5'd13: base6 = 6'b101100;
      5'd14: base6 = 6'b011100;  5'd15: base6 = 6'b010111;
      5'd16: base6 = 6'b011011;  5'd17: base6 = 6'b100011;
      5'd18: base6 = 6'b010011;  5'd19: base6 = 6'b110010;
      5'd20: base6 = 6'b001011;  5'd21: base6 = 6'b101010;
      5'd22: base6 = 6'b011010;  5'd23: base6 = 6'b111010;
      5'd24: base6 = 6'b110011;  5'd25: base6 = 6'b100110;
      5'd26: base6 = 6'b010110;  5'd27: base6 = 6'b110110;
      5'd28: base6 = 6'b001110;  5'd29: base6 = 6'b101110;
      5'd30: base6 = 6'b011110;  default: base6 = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] base4(input logic [2:0] y);
    case (y)
      3'd0: base4 = 4'b1011;  3'd1: base4 = 4'b1001;
      3'd2: base4 = 4'b0101;  3'd3: base4 = 4'b1100;
      3'd4: base4 = 4'b1101;  3'd5: base4 = 4'b1010;
      3'd6: base4 = 4'b0110;  default: base4 = 4'b1110;
    endcase
  endfunction

  function automatic lane_res_t encode_lane(input logic [7:0] d, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       kv;
    logic       flip6;
    logic       unbal4;
    logic       alt7;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd;
    x  = d[4:0];
    y  = d[7:5];
    kv = k && ((x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
    c6    = (kv && (x == 5'd28)) ? 6'b001111 : base6(x);
    flip6 = ($countones(c6) != 3) || (x == 5'd7);
    if (rd_in && flip6) c6 = ~c6;
    rd     = rd_in ^ flip6;
    c4     = base4(y);
    unbal4 = ($countones(c4) != 2);
    alt7   = kv || (!rd && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                   (rd && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    // Neutral K.x.y (y = 1,2,5,6) use the opposite polarity to the data codes
    if (y == 3'd7) c4 = alt7 ? (rd ? 4'b1000 : 4'b0111) : (rd ? 4'b0001 : 4'b1110);
    else if (kv && !unbal4 && (y != 3'd3)) c4 = rd ? c4 : ~c4;
    else if (rd && (unbal4 || (y == 3'd3))) c4 = ~c4;
    encode_lane.code = {c6, c4};
    encode_lane.kerr = k && !kv;
    encode_lane.rd   = rd ^ unbal4;
  endfunction

  logic                rd_q;
  logic                rd_next;
  logic                accept;
  logic [10*LANES-1:0] enc_code;
  logic [LANES-1:0]    enc_kerr;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign rd_out   = rd_q;

  always_comb begin
    lane_res_t res;
    logic      rd_chain;
    res      = '0;
    rd_chain = rd_q;
    enc_code = '0;
    enc_kerr = '0;
    for (int n = 0; n < LANES; n++) begin
      res = encode_lane(in_data[8*n +: 8], in_k[n], rd_chain);
      enc_code[10*n +: 10] = res.code;
      enc_kerr[n]          = res.kerr;
      rd_chain             = res.rd;
    end
    rd_next = rd_chain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_kerr  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_code  <= enc_code;
      out_kerr  <= enc_kerr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A forced load wins over the disparity produced by a beat accepted on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= RD_INIT;
`ifdef ENC8B10B_RD_FORCE_EN
    end else if (rd_force) begin
      rd_q <= rd_force_val;
`endif
    end else if (accept) begin
      rd_q <= rd_next;
    end
  end

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Directed table-driven bench for enc8b10b_lanes: single-lane and dual-lane instances.
module tb_enc8b10b_lanes;

  typedef struct {
    logic [7:0] data;
    logic       k;
    logic [9:0] code;
    logic       kerr;
    logic       rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_k = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  out_code;
  logic        out_kerr;
  logic        rd_out;

  logic        in2_valid = 1'b0;
  logic        in2_ready;
  logic [15:0] in2_data = '0;
  logic [1:0]  in2_k = '0;
  logic        out2_valid;
  logic        out2_ready = 1'b1;
  logic [19:0] out2_code;
  logic [1:0]  out2_kerr;
  logic        rd2_out;

  int total = 0;
  int bad = 0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  enc8b10b_lanes #(.LANES(1), .RD_INIT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_k(in_k), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_kerr(out_kerr), .rd_out(rd_out)
  );

  enc8b10b_lanes #(.LANES(2), .RD_INIT(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
    .in_data(in2_data), .in_k(in2_k), .out_valid(out2_valid), .out_ready(out2_ready),
    .out_code(out2_code), .out_kerr(out2_kerr), .rd_out(rd2_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic k, input logic rdy);
    in_valid  = valid;
    in_data   = data;
    in_k      = k;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0};
    vecs[1]  = '{8'hBC, 1'b1, 10'b0011111010, 1'b0, 1'b1};
    vecs[2]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0};
    vecs[3]  = '{8'hF1, 1'b0, 10'b1000110111, 1'b0, 1'b1};
    vecs[4]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b1};
    vecs[5]  = '{8'h03, 1'b0, 10'b1100010100, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 10'b1001110100, 1'b1, 1'b0};
    vecs[7]  = '{8'h20, 1'b0, 10'b1001111001, 1'b0, 1'b1};
    vecs[8]  = '{8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0};
    vecs[9]  = '{8'hEB, 1'b0, 10'b1101001110, 1'b0, 1'b1};
    vecs[10] = '{8'hF7, 1'b1, 10'b0001010111, 1'b0, 1'b1};
    vecs[11] = '{8'h3C, 1'b1, 10'b1100000110, 1'b0, 1'b0};
    vecs[12] = '{8'h58, 1'b0, 10'b1100110101, 1'b0, 1'b1};
    vecs[13] = '{8'h84, 1'b0, 10'b0010101101, 1'b0, 1'b1};
    vecs[14] = '{8'hE1, 1'b1, 10'b1000101110, 1'b1, 1'b1};

    #23;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_code", 32'(out_code), 32'd0);
    checkOutput("reset out_kerr", 32'(out_kerr), 32'd0);
    checkOutput("reset rd_out", 32'(rd_out), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset lanes2 code", 32'(out2_code), 32'd0);
    rst_n = 1'b1;
    step();

    // Dual-lane disparity chaining
    in2_valid = 1'b1;
    in2_data  = {8'h00, 8'hBC};
    in2_k     = 2'b01;
    step();
    checkOutput("lanes2 beat0 valid", 32'(out2_valid), 32'd1);
    checkOutput("lanes2 beat0 code", 32'(out2_code), 32'({10'b0110001011, 10'b0011111010}));
    checkOutput("lanes2 beat0 kerr", 32'(out2_kerr), 32'd0);
    checkOutput("lanes2 beat0 rd", 32'(rd2_out), 32'd1);
    in2_data = {8'h05, 8'hF1};
    in2_k    = 2'b10;
    step();
    checkOutput("lanes2 beat1 code", 32'(out2_code), 32'({10'b1010011011, 10'b1000110001}));
    checkOutput("lanes2 beat1 kerr", 32'(out2_kerr), 32'd2);
    checkOutput("lanes2 beat1 rd", 32'(rd2_out), 32'd1);
    in2_valid = 1'b0;
    step();
    checkOutput("lanes2 drain valid", 32'(out2_valid), 32'd0);
    checkOutput("lanes2 idle rd", 32'(rd2_out), 32'd1);
    checkOutput("lane1 idle rd", 32'(rd_out), 32'd0);

    // Back-to-back single-lane beats from the table
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, vecs[i].data, vecs[i].k, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      step();
      checkOutput($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d code", i), 32'(out_code), 32'(vecs[i].code));
      checkOutput($sformatf("vec%0d kerr", i), 32'(out_kerr), 32'(vecs[i].kerr));
      checkOutput($sformatf("vec%0d rd", i), 32'(rd_out), 32'(vecs[i].rd));
    end

    // Backpressure: beat A held while beat B waits, then released
    applyStimulus(1'b1, 8'hB5, 1'b0, 1'b1);
    step();
    checkOutput("stall A code", 32'(out_code), 32'(10'b1010101010));
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      step();
      checkOutput($sformatf("stall%0d valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d code", c), 32'(out_code), 32'(10'b1010101010));
      checkOutput($sformatf("stall%0d rd", c), 32'(rd_out), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("release B valid", 32'(out_valid), 32'd1);
    checkOutput("release B code", 32'(out_code), 32'(10'b1100010100));
    checkOutput("release B rd", 32'(rd_out), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkOutput("drain valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("idle valid", 32'(out_valid), 32'd0);
    checkOutput("idle rd", 32'(rd_out), 32'd0);

    // Reset mid-stream drops the held beat and restores RD_INIT
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("pre-reset rd", 32'(rd_out), 32'd0);
    step();
    checkOutput("pre-reset valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, 8'hBC, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset valid", 32'(out_valid), 32'd0);
    checkOutput("midreset code", 32'(out_code), 32'd0);
    checkOutput("midreset rd", 32'(rd_out), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();
    checkOutput("post-reset valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
